// File: rtl/if_pkg.sv
// Shared types for the IF stage: FSM states and the IF/ID bundle.
package if_pkg;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD,
    HOLD_RD
  } if_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
  } if_id_t;

  function automatic if_id_t bubble(
    input logic [31:0] nop
  );
    if_id_t b;
    b.instr = nop;
    b.npc   = 32'h0;
    b.valid = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline latch with hold and bubble control.
// Bubble wins over hold so a flush clears a stalled stage.
module ifid_reg
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   hold_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = q_q;
    if (bubble_i) begin
      q_d = bubble(NOP_WORD);
    end else if (!hold_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= bubble(NOP_WORD);
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/if_fetch_unit.sv
// IF stage: PC register, fetch FSM, stalled-redirect latch.
// Feeds the combinational imem and the IF/ID latch.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_WORDS = 128,
  parameter logic [31:0] NOP_WORD  = NOP_WORD_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] ifid_instr_o,
  output logic [31:0] ifid_npc_o,
  output logic        ifid_valid_o,
  output logic        redir_pend_o
);

  localparam int AW = $clog2(MEM_WORDS);

  if_state_e   state_q;
  if_state_e   state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] tgt_q;
  logic [31:0] tgt_d;

  logic [AW-1:0] pc_inc;
  logic [31:0]   pc_seq;
  logic [31:0]   redir_tgt;
  logic          ifid_hold;
  logic          ifid_bub;
  if_id_t        ifid_d;
  if_id_t        ifid_q;

  assign pc_inc    = pc_q[AW-1:0] + AW'(1);
  assign pc_seq    = {{(32-AW){1'b0}}, pc_inc};
  assign redir_tgt = {{(32-AW){1'b0}}, redirect_pc_i[AW-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      tgt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN,
      HOLD: begin
        if (stall_i) begin
          state_d = redirect_i ? HOLD_RD : HOLD;
        end else begin
          state_d = RUN;
        end
      end
      HOLD_RD: state_d = stall_i ? HOLD_RD : RUN;
      default: state_d = BOOT;
    endcase
  end

  // A redirect seen this cycle beats the latched one.
  always_comb begin
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    ifid_hold = 1'b1;
    ifid_bub  = 1'b0;
    if (state_q == BOOT) begin
      pc_d = pc_q;
    end else if (stall_i) begin
      ifid_bub = flush_i;
      if (redirect_i) begin
        tgt_d = redir_tgt;
      end
    end else begin
      ifid_hold = 1'b0;
      ifid_bub  = flush_i;
      if (redirect_i) begin
        pc_d = redir_tgt;
      end else if (state_q == HOLD_RD) begin
        pc_d = tgt_q;
      end else begin
        pc_d = pc_seq;
      end
    end
  end

  assign ifid_d.instr = imem_data_i;
  assign ifid_d.npc   = pc_seq;
  assign ifid_d.valid = 1'b1;

  ifid_reg #(
    .NOP_WORD(NOP_WORD)
  ) u_ifid (
    .clk     (clk),
    .rst_n   (rst_n),
    .hold_i  (ifid_hold),
    .bubble_i(ifid_bub),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign imem_addr_o  = pc_q;
  assign ifid_instr_o = ifid_q.instr;
  assign ifid_npc_o   = ifid_q.npc;
  assign ifid_valid_o = ifid_q.valid;
  assign redir_pend_o = (state_q == HOLD_RD);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, reset corner,
// then random traffic against a behavioural fetch model.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        redir;
  logic [31:0] redir_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic [31:0] npc;
  logic        valid;
  logic        pend;

  logic [31:0] mem [128];

  int checks = 0;
  int errors = 0;

  if_fetch_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall),
    .flush_i      (flush),
    .redirect_i   (redir),
    .redirect_pc_i(redir_pc),
    .imem_addr_o  (imem_addr),
    .imem_data_i  (imem_data),
    .ifid_instr_o (instr),
    .ifid_npc_o   (npc),
    .ifid_valid_o (valid),
    .redir_pend_o (pend)
  );

  assign imem_data = mem[imem_addr[6:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        s;
    logic        f;
    logic        r;
    logic [31:0] t;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    logic        pend;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic s, f, r, input logic [31:0] t,
                     input logic [31:0] a, i, n,
                     input logic v, p);
    vec_t x;
    x.s = s; x.f = f; x.r = r; x.t = t;
    x.addr = a; x.instr = i; x.npc = n;
    x.valid = v; x.pend = p;
    vt.push_back(x);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act, exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm,
                         input logic [31:0] a, i, n,
                         input logic v, p);
    chk({nm, " addr"},  imem_addr, a);
    chk({nm, " instr"}, instr, i);
    chk({nm, " npc"},   npc, n);
    chk({nm, " valid"}, 32'(valid), 32'(v));
    chk({nm, " pend"},  32'(pend), 32'(p));
  endtask

  // Behavioural model: a PC, an optional pending target and the
  // IF/ID contents, advanced once per clock from the rules.
  bit          m_boot;
  int unsigned m_pc;
  bit          m_pend;
  int unsigned m_tgt;
  logic [31:0] m_instr;
  int unsigned m_npc;
  bit          m_valid;

  task automatic model_reset();
    m_boot = 0; m_pc = 0; m_pend = 0; m_tgt = 0;
    m_instr = 32'h0; m_npc = 0; m_valid = 0;
  endtask

  task automatic model_step(input bit s, f, r,
                            input logic [31:0] t);
    int unsigned nxt;
    if (!m_boot) begin
      m_boot = 1;
      return;
    end
    if (s) begin
      if (f) begin
        m_instr = 32'h0; m_npc = 0; m_valid = 0;
      end
      if (r) begin
        m_pend = 1;
        m_tgt = t % 128;
      end
    end else begin
      if (r) nxt = t % 128;
      else if (m_pend) nxt = m_tgt;
      else nxt = (m_pc + 1) % 128;
      if (f) begin
        m_instr = 32'h0; m_npc = 0; m_valid = 0;
      end else begin
        m_instr = mem[m_pc];
        m_npc = (m_pc + 1) % 128;
        m_valid = 1;
      end
      m_pc = nxt;
      m_pend = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'hA500_0000 | i;
    mem[0] = 32'h0023_00AA;
    mem[1] = 32'h1065_4321;
    mem[2] = 32'h0010_0022;

    add(0,0,0,0,   0,  32'h0,          0, 0, 0);
    add(0,0,0,0,   1,  32'h0023_00AA,  1, 1, 0);
    add(0,0,0,0,   2,  32'h1065_4321,  2, 1, 0);
    add(1,0,0,0,   2,  32'h1065_4321,  2, 1, 0);
    add(1,0,0,0,   2,  32'h1065_4321,  2, 1, 0);
    add(1,0,0,0,   2,  32'h1065_4321,  2, 1, 0);
    add(0,0,0,0,   3,  32'h0010_0022,  3, 1, 0);
    add(1,0,1,8,   3,  32'h0010_0022,  3, 1, 1);
    add(0,0,0,0,   8,  32'hA500_0003,  4, 1, 0);
    add(0,0,0,0,   9,  32'hA500_0008,  9, 1, 0);
    add(1,0,1,20,  9,  32'hA500_0008,  9, 1, 1);
    add(1,0,1,5,   9,  32'hA500_0008,  9, 1, 1);
    add(1,1,0,0,   9,  32'h0,          0, 0, 1);
    add(0,1,0,0,   5,  32'h0,          0, 0, 0);
    add(0,0,0,0,   6,  32'hA500_0005,  6, 1, 0);
    add(0,0,1,127, 127,32'hA500_0006,  7, 1, 0);
    add(0,0,0,0,   0,  32'hA500_007F,  0, 1, 0);
    add(0,0,1,32'h85, 5, 32'h0023_00AA, 1, 1, 0);
    add(0,0,0,0,   6,  32'hA500_0005,  6, 1, 0);
    add(1,0,1,10,  6,  32'hA500_0005,  6, 1, 1);
    add(0,0,1,12,  12, 32'hA500_0006,  7, 1, 0);
    add(1,0,1,40,  12, 32'hA500_0006,  7, 1, 1);

    rst_n = 1'b0;
    stall = 0; flush = 0; redir = 0; redir_pc = 0;
    #1;
    chk_all("reset", 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      stall = vt[i].s; flush = vt[i].f;
      redir = vt[i].r; redir_pc = vt[i].t;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vt[i].addr,
              vt[i].instr, vt[i].npc, vt[i].valid, vt[i].pend);
    end

    // Asynchronous reset while a redirect to 40 is pending.
    stall = 0; flush = 0; redir = 0; redir_pc = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 32'h0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst_boot", 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("post_rst_fetch", 1, 32'h0023_00AA, 1, 1, 0);

    // Random traffic from a fresh reset.
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 800; i++) begin
      bit s, f, r;
      logic [31:0] t;
      s = ($urandom_range(0, 9) < 3);
      f = ($urandom_range(0, 9) < 2);
      r = ($urandom_range(0, 9) < 2);
      t = $urandom;
      stall = s; flush = f; redir = r; redir_pc = t;
      model_step(s, f, r, t);
      @(posedge clk);
      #1;
      chk_all($sformatf("rnd%0d", i), m_pc, m_instr, m_npc,
              m_valid, m_pend);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch control for the IF stage of the five-stage pipeline. Holds the program counter, drives the word address into the combinational instruction memory, and registers the returned word with its next-PC into the IF/ID pipeline register. Handles stalls from the hazard unit, flushes and branch redirects from later stages, and holds a redirect that arrives during a stall until the stall releases.

## Interface
- RESET_PC, 32'h0000_0000, word address fetched first after reset
- MEM_WORDS, 128, instruction-memory depth in words; must be a power of two
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble
- Clock and reset: one clock, `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall_i  in  1  hold PC and IF/ID contents
- flush_i  in  1  load bubble into IF/ID
- redirect_i  in  1  branch/jump taken this cycle
- redirect_pc_i  in  32  target word address
- imem_addr_o  out  32  word address to instruction memory (= PC)
- imem_data_i  in  32  instruction word, combinational from imem_addr_o
- ifid_instr_o  out  32  registered instruction
- ifid_npc_o  out  32  registered PC+1 of that instruction
- ifid_valid_o  out  1  IF/ID holds a real instruction
- redir_pend_o  out  1  a redirect is latched awaiting stall release

## Operation
- PC is a word address. next sequential = (PC+1) mod MEM_WORDS. Redirect targets are reduced mod MEM_WORDS (low log2(MEM_WORDS) bits kept, upper bits zero).
- FSM states: BOOT, RUN, HOLD, HOLD_RD.
- BOOT: entered on reset. PC=RESET_PC. On the first edge after reset release, go to RUN. IF/ID stays invalid. PC stays unchanged. The fetch of RESET_PC is first captured at the following edge.
- RUN, no stall:
  - PC <= redirect ? target : PC+1.
  - IF/ID <= flush ? bubble : {imem_data_i, PC+1, valid=1}.
- RUN with stall:
  - PC and IF/ID hold.
  - If flush also asserted, IF/ID <= bubble; flush overrides stall for IF/ID only.
  - Next state is HOLD_RD if redirect_i is set, else HOLD.
- HOLD: same hold rules as RUN with stall.
  - redirect_i with stall → HOLD_RD.
  - stall low → act as RUN this cycle.
- HOLD_RD: target latched in an internal register; redir_pend_o=1.
  - A newer redirect_i overwrites the latched target.
  - On stall low, PC <= latched or new target (new wins), then → RUN.
  - The IF/ID update follows the RUN rule.
- Bubble: instr=NOP_WORD, npc=0, valid=0.
- Reset mid-operation: all state is cleared immediately and any pending redirect is discarded.

## Timing
- Reset values:
  - imem_addr_o=RESET_PC
  - ifid_instr_o=NOP_WORD
  - ifid_npc_o=0
  - ifid_valid_o=0
  - redir_pend_o=0
  - state=BOOT
- imem_addr_o is driven directly from the PC register with no combinational path from any input.
- Latency: the word at PC appears on ifid_instr_o one edge after PC is presented.
- Redirect accepted at edge N: target is on imem_addr_o after N. The instruction at the target is in IF/ID after N+1.
- The wrong-path word fetched in cycle N is removed only by flush_i; the unit does not flush on its own.
- Wrap: PC=MEM_WORDS-1 with no redirect → PC=0 at the next edge; ifid_npc_o=0 for that word.

## Structure
- Shared package `if_pkg`:
  - state enum (BOOT/RUN/HOLD/HOLD_RD)
  - default NOP_WORD
  - IF/ID bundle struct {instr, npc, valid}
- Sub-module `ifid_reg`: the IF/ID pipeline register with hold/bubble control, reused for later pipeline latches.
- The PC, FSM and redirect latch stay in the top module.

## Test plan
- Bench preload: imem word 0=0x002300AA, 1=0x10654321, 2=0x00100022.
- Reset then free-run, no stall → after 2 edges: ifid_instr_o=0x002300AA, npc=1, valid=1; next edge 0x10654321, npc=2.
- stall_i high for 3 cycles at PC=2 → imem_addr_o stays 2 and IF/ID stays 0x10654321/npc 2; on release, 0x00100022 is captured.
- redirect_i with target 8 while stall_i high → redir_pend_o=1. Stall drops → PC=8 one edge later and redir_pend_o=0.
- Second redirect (target 5) while in HOLD_RD, then release → PC=5.
- flush_i together with stall_i → ifid_valid_o=0 and instr=NOP_WORD; PC held.
- PC=127 → next PC=0.
- redirect to 0x0000_0085 → PC=5.
- Assert rst_n low mid-HOLD_RD → all outputs return to their reset values immediately with no clock edge, and the pending target is lost.
